// File: rtl/timer_sequencer.sv
// Control FSM for the kitchen-timer MM:SS BCD countdown: set-point editing, load, run/pause, alarm.
// Build option: define ALARM_BLINK_EN to make the alarm output toggle on every 1 Hz tick.
module timer_sequencer #(
  parameter int MAX_MIN    = 59,
  parameter int ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_start,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       btn_clear,
  input  logic       cnt_zero,
  output logic       load,
  output logic       cnt_en,
  output logic [3:0] set_m1,
  output logic [3:0] set_m0,
  output logic [3:0] set_s1,
  output logic [3:0] set_s0,
  output logic       alarm,
  output logic       disp_sel,
  output logic [2:0] state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_ALARM = 3'd4;

  localparam logic [3:0] MAX_M1_C    = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_M0_C    = 4'(MAX_MIN % 10);
  localparam logic [3:0] ACNT_LAST_C = 4'(ALARM_SECS - 1);

  logic [2:0] state_r, state_nxt_s;
  logic [3:0] set_m1_r, set_m0_r, set_s1_r, set_s0_r;
  logic [3:0] m1_nxt_s, m0_nxt_s, s1_nxt_s, s0_nxt_s;
  logic [3:0] acnt_r, acnt_nxt_s;
  logic       load_r, load_nxt_s;
  logic       alarm_r, alarm_nxt_s;
  logic       disp_sel_r, disp_sel_nxt_s;
  logic       any_btn_s, setpoint_zero_s, alarm_done_s, idle_edit_s;

  assign any_btn_s       = btn_clear | btn_start | btn_min | btn_sec;
  assign setpoint_zero_s = ({set_m1_r, set_m0_r, set_s1_r, set_s0_r} == 16'd0);
  assign alarm_done_s    = tick_1hz & (acnt_r == ACNT_LAST_C);
  // min/sec edits only act when no higher-priority button shares the cycle
  assign idle_edit_s     = (state_r == ST_IDLE) & ~btn_clear & ~btn_start;

  // Next-state decode; clear outranks expiry, expiry outranks start/pause.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (!btn_clear && btn_start && !setpoint_zero_s) state_nxt_s = ST_LOAD;
        else                                             state_nxt_s = ST_IDLE;
      end
      ST_LOAD: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (btn_clear)      state_nxt_s = ST_IDLE;
        else if (cnt_zero)  state_nxt_s = ST_ALARM;
        else if (btn_start) state_nxt_s = ST_PAUSE;
        else                state_nxt_s = ST_RUN;
      end
      ST_PAUSE: begin
        if (btn_clear)      state_nxt_s = ST_IDLE;
        else if (btn_start) state_nxt_s = ST_RUN;
        else                state_nxt_s = ST_PAUSE;
      end
      ST_ALARM: begin
        if (any_btn_s || alarm_done_s) state_nxt_s = ST_IDLE;
        else                            state_nxt_s = ST_ALARM;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Set-point BCD editing, active only in IDLE.
  always_comb begin
    m1_nxt_s = set_m1_r;
    m0_nxt_s = set_m0_r;
    s1_nxt_s = set_s1_r;
    s0_nxt_s = set_s0_r;
    if (state_r == ST_IDLE && btn_clear) begin
      m1_nxt_s = 4'd0;
      m0_nxt_s = 4'd0;
      s1_nxt_s = 4'd0;
      s0_nxt_s = 4'd0;
    end else if (idle_edit_s && btn_min) begin
      if (set_m1_r == MAX_M1_C && set_m0_r == MAX_M0_C) begin
        m1_nxt_s = 4'd0;
        m0_nxt_s = 4'd0;
      end else if (set_m0_r == 4'd9) begin
        m1_nxt_s = set_m1_r + 4'd1;
        m0_nxt_s = 4'd0;
      end else begin
        m0_nxt_s = set_m0_r + 4'd1;
      end
    end else if (idle_edit_s && btn_sec) begin
      if (set_s1_r == 4'd5 && set_s0_r == 4'd9) begin
        s1_nxt_s = 4'd0;
        s0_nxt_s = 4'd0;
      end else if (set_s0_r == 4'd9) begin
        s1_nxt_s = set_s1_r + 4'd1;
        s0_nxt_s = 4'd0;
      end else begin
        s0_nxt_s = set_s0_r + 4'd1;
      end
    end else begin
      m1_nxt_s = set_m1_r;
      m0_nxt_s = set_m0_r;
      s1_nxt_s = set_s1_r;
      s0_nxt_s = set_s0_r;
    end
  end

  // Output decode from the next state so the registered outputs line up with state.
  always_comb begin
    load_nxt_s     = (state_nxt_s == ST_LOAD);
    disp_sel_nxt_s = (state_nxt_s != ST_IDLE);
    acnt_nxt_s     = 4'd0;
    alarm_nxt_s    = 1'b0;
    if (state_r == ST_ALARM && state_nxt_s == ST_ALARM) begin
      acnt_nxt_s = acnt_r + {3'd0, tick_1hz};
`ifdef ALARM_BLINK_EN
      alarm_nxt_s = alarm_r ^ tick_1hz;
`else
      alarm_nxt_s = 1'b1;
`endif
    end else if (state_nxt_s == ST_ALARM) begin
      acnt_nxt_s  = 4'd0;
      alarm_nxt_s = 1'b1;
    end else begin
      acnt_nxt_s  = 4'd0;
      alarm_nxt_s = 1'b0;
    end
  end

  // State, set-point and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      set_m1_r   <= 4'd0;
      set_m0_r   <= 4'd0;
      set_s1_r   <= 4'd0;
      set_s0_r   <= 4'd0;
      acnt_r     <= 4'd0;
      load_r     <= 1'b0;
      alarm_r    <= 1'b0;
      disp_sel_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      set_m1_r   <= m1_nxt_s;
      set_m0_r   <= m0_nxt_s;
      set_s1_r   <= s1_nxt_s;
      set_s0_r   <= s0_nxt_s;
      acnt_r     <= acnt_nxt_s;
      load_r     <= load_nxt_s;
      alarm_r    <= alarm_nxt_s;
      disp_sel_r <= disp_sel_nxt_s;
    end
  end

  // cnt_en is the only combinational output; it can never fire at zero or in LOAD.
  assign cnt_en   = (state_r == ST_RUN) & tick_1hz & ~cnt_zero;
  assign load     = load_r;
  assign alarm    = alarm_r;
  assign disp_sel = disp_sel_r;
  assign state    = state_r;
  assign set_m1   = set_m1_r;
  assign set_m0   = set_m0_r;
  assign set_s1   = set_s1_r;
  assign set_s0   = set_s0_r;

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer: vector table, directed corner sequences and
// randomized stimulus against a cycle-level reference model with an emulated countdown datapath.
module tb_timer_sequencer;

  localparam int MAX_MIN    = 59;
  localparam int ALARM_SECS = 10;
  localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_PAUSE = 3, S_ALARM = 4;
`ifdef ALARM_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, tick_1hz, btn_start, btn_min, btn_sec, btn_clear, cnt_zero;
  logic load, cnt_en, alarm, disp_sel;
  logic [3:0] set_m1, set_m0, set_s1, set_s0;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int dp_secs = 0;
  logic last_cnt_en;

  // reference model: mode plus set-point as plain integers
  int m_state = S_IDLE;
  int m_min = 0, m_sec = 0, m_acnt = 0;
  bit m_lvl = 1'b0;

  always #5 clk = ~clk;

  timer_sequencer #(.MAX_MIN(MAX_MIN), .ALARM_SECS(ALARM_SECS)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .btn_start(btn_start),
    .btn_min(btn_min), .btn_sec(btn_sec), .btn_clear(btn_clear), .cnt_zero(cnt_zero),
    .load(load), .cnt_en(cnt_en), .set_m1(set_m1), .set_m0(set_m0), .set_s1(set_s1),
    .set_s0(set_s0), .alarm(alarm), .disp_sel(disp_sel), .state(state)
  );

  // emulated countdown datapath in total seconds; underflow wraps to 99:59 so it is visible
  assign cnt_zero = (dp_secs == 0);
  always @(posedge clk) begin
    if (!reset) dp_secs <= 0;
    else if (load) dp_secs <= 600 * int'(set_m1) + 60 * int'(set_m0) + 10 * int'(set_s1) + int'(set_s0);
    else if (cnt_en) dp_secs <= (dp_secs == 0) ? 5999 : dp_secs - 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int exp_set();
    return ((m_min / 10) << 12) | ((m_min % 10) << 8) | ((m_sec / 10) << 4) | (m_sec % 10);
  endfunction

  function automatic int act_set();
    return int'({set_m1, set_m0, set_s1, set_s0});
  endfunction

  task automatic model_update(input bit rst, input bit clr, input bit st, input bit mn,
                              input bit sc, input bit tk, input bit z);
    bit any;
    any = clr | st | mn | sc;
    if (rst) begin
      m_state = S_IDLE; m_min = 0; m_sec = 0; m_acnt = 0; m_lvl = 1'b0;
    end else begin
      case (m_state)
        S_IDLE: begin
          if (clr) begin m_min = 0; m_sec = 0; end
          else if (st) begin if (m_min + m_sec > 0) m_state = S_LOAD; end
          else if (mn) m_min = (m_min == MAX_MIN) ? 0 : m_min + 1;
          else if (sc) m_sec = (m_sec == 59) ? 0 : m_sec + 1;
        end
        S_LOAD: m_state = S_RUN;
        S_RUN: begin
          if (clr) m_state = S_IDLE;
          else if (z) begin m_state = S_ALARM; m_acnt = 0; m_lvl = 1'b1; end
          else if (st) m_state = S_PAUSE;
        end
        S_PAUSE: begin
          if (clr) m_state = S_IDLE;
          else if (st) m_state = S_RUN;
        end
        S_ALARM: begin
          if (any) m_state = S_IDLE;
          else if (tk) begin
            m_acnt++;
            if (m_acnt == ALARM_SECS) m_state = S_IDLE;
            else m_lvl = !m_lvl;
          end
        end
        default: m_state = S_IDLE;
      endcase
    end
  endtask

  // one clock: drive at negedge, check cnt_en before the edge, check registered outputs after
  task automatic step(input bit rst, input bit clr, input bit st, input bit mn,
                      input bit sc, input bit tk);
    bit z;
    reset = !rst; btn_clear = clr; btn_start = st; btn_min = mn; btn_sec = sc; tick_1hz = tk;
    #1;
    z = cnt_zero;
    last_cnt_en = cnt_en;
    chk("cnt_en", int'(cnt_en), int'(m_state == S_RUN && tk && !z));
    chk("load_cnt_en_exclusive", int'(load & cnt_en), 0);
    @(posedge clk);
    model_update(rst, clr, st, mn, sc, tk, z);
    @(negedge clk);
    chk("state", int'(state), m_state);
    chk("load", int'(load), int'(m_state == S_LOAD));
    chk("disp_sel", int'(disp_sel), int'(m_state != S_IDLE));
    chk("alarm", int'(alarm), int'(m_state == S_ALARM && (BLINK ? m_lvl : 1'b1)));
    chk("setpoint", act_set(), exp_set());
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit clr, st, mn, sc;
    int exp_state;
    int exp_set;
    bit exp_load;
  } vec_t;

  function automatic vec_t mk(bit clr, bit st, bit mn, bit sc, int es, int eset, bit el);
    vec_t v;
    v.clr = clr; v.st = st; v.mn = mn; v.sc = sc;
    v.exp_state = es; v.exp_set = eset; v.exp_load = el;
    return v;
  endfunction

  initial begin
    vec_t tbl[13];
    int n;
    int exp_al;
    tbl[0]  = mk(0, 0, 0, 1, S_IDLE, 'h0001, 0);
    tbl[1]  = mk(0, 0, 0, 1, S_IDLE, 'h0002, 0);
    tbl[2]  = mk(0, 0, 1, 0, S_IDLE, 'h0102, 0);
    tbl[3]  = mk(0, 0, 1, 1, S_IDLE, 'h0202, 0);  // min beats sec
    tbl[4]  = mk(1, 0, 1, 0, S_IDLE, 'h0000, 0);  // clear beats min
    tbl[5]  = mk(0, 1, 0, 0, S_IDLE, 'h0000, 0);  // start at 00:00 ignored
    tbl[6]  = mk(0, 0, 0, 1, S_IDLE, 'h0001, 0);
    tbl[7]  = mk(1, 1, 0, 0, S_IDLE, 'h0000, 0);  // clear beats start
    tbl[8]  = mk(0, 0, 0, 1, S_IDLE, 'h0001, 0);
    tbl[9]  = mk(0, 0, 0, 1, S_IDLE, 'h0002, 0);
    tbl[10] = mk(0, 0, 0, 1, S_IDLE, 'h0003, 0);
    tbl[11] = mk(0, 1, 0, 0, S_LOAD, 'h0003, 1);
    tbl[12] = mk(0, 0, 0, 0, S_RUN,  'h0003, 0);

    reset = 1'b0; btn_clear = 1'b0; btn_start = 1'b0; btn_min = 1'b0; btn_sec = 1'b0;
    tick_1hz = 1'b0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_state", int'(state), S_IDLE);
    chk("reset_alarm", int'(alarm), 0);

    foreach (tbl[i]) begin
      step(0, tbl[i].clr, tbl[i].st, tbl[i].mn, tbl[i].sc, 0);
      chk("tbl_state", int'(state), tbl[i].exp_state);
      chk("tbl_set", act_set(), tbl[i].exp_set);
      chk("tbl_load", int'(load), int'(tbl[i].exp_load));
    end

    // countdown from 00:03: three decrements, fourth tick blocked at zero
    n = 0;
    step(0, 0, 0, 0, 0, 1); n += int'(last_cnt_en); idle_n(1);
    step(0, 0, 0, 0, 0, 1); n += int'(last_cnt_en); idle_n(1);
    step(0, 0, 0, 0, 0, 1); n += int'(last_cnt_en);
    chk("run_cnt_en_pulses", n, 3);
    chk("dp_at_zero", dp_secs, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("underflow_guard", int'(last_cnt_en), 0);
    chk("enter_alarm", int'(state), S_ALARM);
    chk("alarm_on_entry", int'(alarm), 1);
    for (int k = 1; k <= ALARM_SECS; k++) begin
      step(0, 0, 0, 0, 0, 1);
      if (k < ALARM_SECS) begin
        exp_al = BLINK ? int'(k % 2 == 0) : 1;
        chk("alarm_level", int'(alarm), exp_al);
        chk("alarm_hold", int'(state), S_ALARM);
        idle_n(1);
      end
    end
    chk("alarm_timeout_idle", int'(state), S_IDLE);
    chk("alarm_timeout_off", int'(alarm), 0);
    chk("setpoint_retained", act_set(), 'h0003);

    // pause / resume from 00:07
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
    chk("set_0007", act_set(), 'h0007);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("run_tick", int'(last_cnt_en), 1);
    step(0, 0, 1, 0, 0, 1);
    chk("pause_tick_decrements", int'(last_cnt_en), 1);
    chk("pause_entered", int'(state), S_PAUSE);
    n = 0;
    for (int i = 0; i < 5; i++) begin step(0, 0, 0, 0, 0, 1); n += int'(last_cnt_en); end
    chk("pause_no_cnt_en", n, 0);
    chk("pause_dp_held", dp_secs, 5);
    step(0, 0, 1, 0, 0, 0);
    chk("resume_run", int'(state), S_RUN);
    step(0, 0, 0, 0, 0, 1);
    chk("resume_tick", int'(last_cnt_en), 1);
    step(0, 1, 1, 0, 0, 0);
    chk("clear_beats_start_run", int'(state), S_IDLE);

    // reset in the middle of a run
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("run_before_reset", int'(state), S_RUN);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_state", int'(state), S_IDLE);
    chk("rst_set", act_set(), 'h0000);
    chk("rst_load", int'(load), 0);
    chk("rst_alarm", int'(alarm), 0);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_cnt_en", int'(last_cnt_en), 0);

    // set-point wrap boundaries
    for (int i = 0; i < 61; i++) step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
    chk("set_0301", act_set(), 'h0301);
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 59; i++) step(0, 0, 0, 1, 0, 0);
    chk("set_5900", act_set(), 'h5900);
    step(0, 0, 0, 1, 0, 0);
    chk("min_wrap", act_set(), 'h0000);

    // alarm acknowledged by btn_sec
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("ack_in_alarm", int'(state), S_ALARM);
    chk("ack_alarm_on", int'(alarm), 1);
    step(0, 0, 0, 0, 1, 0);
    chk("ack_idle", int'(state), S_IDLE);
    chk("ack_alarm_off", int'(alarm), 0);
    chk("ack_set_kept", act_set(), 'h0001);

    // randomized traffic against the reference model
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
